muldiv_unit: RTL and testbench

- Iterative unsigned multiply/divide execution unit that sits between register-file reads and register-file write-back.
- Consumes two operand words (the rs1/rs2 read values) plus a 4-bit destination index.
- Computes over DBITS cycles, then presents a one-cycle write request (wrt_en, rd_out, result) that drives the register file write port directly.
- Core control stalls on busy.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_unit.sv | 119 +++++++++++
 tb/tb_muldiv_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings and sizing helper for the iterative mul/div unit
package muldiv_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int cnt_width(input int dbits);
    return (dbits < 2) ? 1 : $clog2(dbits);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring-divide trial subtract
module muldiv_step #(
  parameter int DBITS = 32
) (
  input  logic             is_div,
  input  logic [DBITS-1:0] acc_in,
  input  logic [DBITS-1:0] lo_in,
  input  logic [DBITS-1:0] b_in,
  output logic [DBITS-1:0] acc_out,
  output logic [DBITS-1:0] lo_out
);

  logic [DBITS:0] sum;
  logic [DBITS:0] shifted;
  logic           ge;

  always_comb begin
    // Multiply: acc:lo is the product register, lo[0] is the next multiplier bit.
    sum     = {1'b0, acc_in} + {1'b0, (lo_in[0] ? b_in : {DBITS{1'b0}})};
    // Divide: acc is the partial remainder, lo shifts dividend out and quotient in.
    shifted = {acc_in, lo_in[DBITS-1]};
    ge      = (shifted >= {1'b0, b_in});
    acc_out = '0;
    lo_out  = '0;
    if (is_div) begin
      // A passing trial leaves a remainder below b_in, so DBITS bits suffice.
      acc_out = ge ? (shifted[DBITS-1:0] - b_in) : shifted[DBITS-1:0];
      lo_out  = {lo_in[DBITS-2:0], ge};
    end else begin
      acc_out = sum[DBITS:1];
      lo_out  = {sum[0], lo_in[DBITS-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned MUL/MULHU/DIVU/REMU with a one-cycle register-file write request
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [DBITS-1:0] opa,
  input  logic [DBITS-1:0] opb,
  input  logic [3:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic             wrt_en,
  output logic [3:0]       rd_out,
  output logic [DBITS-1:0] result
);

  localparam int CW = cnt_width(DBITS);
  localparam logic [CW-1:0] LAST = CW'(DBITS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [DBITS-1:0] acc_q, acc_d;
  logic [DBITS-1:0] lo_q, lo_d;
  logic [DBITS-1:0] b_q, b_d;
  logic [3:0]       rd_q, rd_d;
  logic [3:0]       rd_out_q, rd_out_d;
  logic [DBITS-1:0] result_q, result_d;

  logic             is_div;
  logic [DBITS-1:0] step_acc, step_lo;

  assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

  muldiv_step #(.DBITS(DBITS)) u_step (
    .is_div  (is_div),
    .acc_in  (acc_q),
    .lo_in   (lo_q),
    .b_in    (b_q),
    .acc_out (step_acc),
    .lo_out  (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    b_d      = b_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          acc_d   = '0;
          lo_d    = opa;
          b_d     = opb;
          rd_d    = rd_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          rd_out_d = rd_q;
          // Low product and quotient both end up in lo; high product and remainder in acc.
          case (op_q)
            OP_MUL, OP_DIVU: result_d = step_lo;
            default:         result_d = step_acc;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == RUN) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign wrt_en = (state_q == DONE);
  assign rd_out = rd_out_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vectors with a scoreboard queue and an independent write-port monitor
module tb_muldiv_unit;

  localparam int DBITS = 32;
  localparam int LAT   = DBITS + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [1:0]       op;
  logic [DBITS-1:0] opa, opb;
  logic [3:0]       rd_in;
  logic             busy, done, wrt_en;
  logic [3:0]       rd_out;
  logic [DBITS-1:0] result;

  typedef struct {
    logic [DBITS-1:0] res;
    logic [3:0]       rd;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  muldiv_unit #(.DBITS(DBITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .wrt_en  (wrt_en),
    .rd_out  (rd_out),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write request must match the oldest expected entry, including its cycle.
  always @(negedge clk) begin
    if (reset_n && wrt_en) begin
      chk("done_eq_wrt_en", {63'd0, done}, 64'd1);
      if (sb.size() == 0) begin
        chk("unexpected_write", {60'd0, rd_out}, 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {32'd0, result}, {32'd0, e.res});
        chk("rd_out", {60'd0, rd_out}, {60'd0, e.rd});
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [DBITS-1:0] a, input logic [DBITS-1:0] b,
                        input logic [3:0] rd, input logic [DBITS-1:0] exp_res, output int c0);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
    op = o; opa = a; opb = b; rd_in = rd; start = 1'b1;
    c0 = cyc;
    sb.push_back('{res: exp_res, rd: rd, cyc: c0 + LAT});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int c0;
    int n;
    reset_n = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {63'd0, busy},   64'd0);
    chk("rst_done",   {63'd0, done},   64'd0);
    chk("rst_wrt_en", {63'd0, wrt_en}, 64'd0);
    chk("rst_rd_out", {60'd0, rd_out}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    reset_n = 1'b1;

    // Busy/done profile relative to the start cycle.
    run_op(2'b00, 32'd7, 32'd6, 4'd3, 32'd42, c0);
    for (int i = 1; i <= 35; i++) begin
      chk("busy_profile", {63'd0, busy}, {63'd0, (i <= LAT)});
      chk("done_profile", {63'd0, done}, {63'd0, (i == LAT)});
      @(negedge clk);
    end

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4,  32'hFFFF_FFFE, c0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5,  32'h0000_0001, c0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,         4'd6,  32'hFFFF_FFF1, c0);
    run_op(2'b10, 32'd100,       32'd7,         4'd7,  32'd14,        c0);
    run_op(2'b11, 32'd100,       32'd7,         4'd8,  32'd2,         c0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1,         4'd10, 32'hFFFF_FFFF, c0);
    run_op(2'b10, 32'h1234,      32'd0,         4'd11, 32'hFFFF_FFFF, c0);
    run_op(2'b11, 32'h1234,      32'd0,         4'd13, 32'h1234,      c0);

    // Starts while busy must be ignored; the first IDLE cycle accepts a new start.
    run_op(2'b10, 32'd1000, 32'd10, 4'd9, 32'd100, c0);
    repeat (5) @(negedge clk);
    op = 2'b00; opa = 32'd99; opb = 32'd99; rd_in = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("saw_done", {63'd0, done}, 64'd1);
    op = 2'b11; opa = 32'd55; opb = 32'd3; rd_in = 4'd14; start = 1'b1;
    run_op(2'b01, 32'h0001_0000, 32'h0003_0000, 4'd12, 32'd3, c0);
    chk("first_idle_accept", 64'(c0), 64'(sb[0].cyc - LAT));

    // Asynchronous reset in the middle of RUN discards the operation.
    run_op(2'b00, 32'hFFFF, 32'hFFFF, 4'd2, 32'hFFFE_0001, c0);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("mid_rst_busy",   {63'd0, busy},   64'd0);
    chk("mid_rst_done",   {63'd0, done},   64'd0);
    chk("mid_rst_wrt_en", {63'd0, wrt_en}, 64'd0);
    chk("mid_rst_rd_out", {60'd0, rd_out}, 64'd0);
    chk("mid_rst_result", {32'd0, result}, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_write_after_rst", {63'd0, wrt_en}, 64'd0);
    run_op(2'b00, 32'd3, 32'd5, 4'd1, 32'd15, c0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
